mem_arbiter: RTL and testbench

//  Shares one memory/cache port between the fetch path (imem_*) and the mem stage (dmem_*).

---
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch (imem) and mem stage (dmem): captures one-cycle requests,
// arbitrates with dmem priority and bounded imem starvation, and routes responses to the owner.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

  state_t        state, state_next;
  owner_t        owner;
  logic          i_pend, d_pend;
  logic [31:0]   i_addr, d_addr, d_wdata;
  logic [3:0]    i_rmask, d_rmask, d_wmask;
  logic [SW-1:0] starve_cnt;

  logic          resp_fire, arb, i_busy, d_busy, i_new, d_new, i_cand, d_cand;
  logic          imem_wins, grant_i, grant_d;
  logic [31:0]   ci_addr, cd_addr, cd_wdata;
  logic [3:0]    ci_rmask, cd_rmask, cd_wmask;

  // A requester whose transaction completes this cycle may already present its next request.
  assign resp_fire = (state == WAIT) && mem_resp;
  assign arb       = (state == IDLE) || resp_fire;
  assign i_busy    = (state == WAIT) && (owner == OWN_I) && !mem_resp;
  assign d_busy    = (state == WAIT) && (owner == OWN_D) && !mem_resp;
  assign i_new     = (|imem_rmask) && !i_pend && !i_busy;
  assign d_new     = (|(dmem_rmask | dmem_wmask)) && !d_pend && !d_busy;
  assign i_cand    = i_pend || i_new;
  assign d_cand    = d_pend || d_new;

  assign ci_addr   = i_pend ? i_addr  : imem_addr;
  assign ci_rmask  = i_pend ? i_rmask : imem_rmask;
  assign cd_addr   = d_pend ? d_addr  : dmem_addr;
  assign cd_rmask  = d_pend ? d_rmask : dmem_rmask;
  assign cd_wmask  = d_pend ? d_wmask : dmem_wmask;
  assign cd_wdata  = d_pend ? d_wdata : dmem_wdata;

  assign imem_wins = i_cand && (!d_cand || (starve_cnt == LIMIT));
  assign grant_i   = arb && imem_wins;
  assign grant_d   = arb && d_cand && !imem_wins;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    if (arb) state_next = (grant_i || grant_d) ? WAIT : IDLE;
  end

  always_comb begin
    imem_resp  = 1'b0;
    imem_rdata = '0;
    dmem_resp  = 1'b0;
    dmem_rdata = '0;
    if (resp_fire) begin
      if (owner == OWN_I) begin
        imem_resp  = 1'b1;
        imem_rdata = mem_rdata;
      end else begin
        dmem_resp  = 1'b1;
        dmem_rdata = mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= OWN_I;
      i_pend     <= 1'b0;
      i_addr     <= '0;
      i_rmask    <= '0;
      d_pend     <= 1'b0;
      d_addr     <= '0;
      d_rmask    <= '0;
      d_wmask    <= '0;
      d_wdata    <= '0;
      starve_cnt <= '0;
      mem_addr   <= '0;
      mem_rmask  <= '0;
      mem_wmask  <= '0;
      mem_wdata  <= '0;
    end else begin
      i_pend <= (i_pend || i_new) && !grant_i;
      d_pend <= (d_pend || d_new) && !grant_d;
      if (i_new) begin
        i_addr  <= imem_addr;
        i_rmask <= imem_rmask;
      end
      if (d_new) begin
        d_addr  <= dmem_addr;
        d_rmask <= dmem_rmask;
        d_wmask <= dmem_wmask;
        d_wdata <= dmem_wdata;
      end

      if (!i_cand || grant_i)                  starve_cnt <= '0;
      else if (grant_d && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;

      // Masks pulse for the issue cycle only; addr/wdata hold until the next issue.
      mem_rmask <= '0;
      mem_wmask <= '0;
      if (grant_i) begin
        owner     <= OWN_I;
        mem_addr  <= ci_addr;
        mem_rmask <= ci_rmask;
        mem_wdata <= '0;
      end else if (grant_d) begin
        owner     <= OWN_D;
        mem_addr  <= cd_addr;
        mem_rmask <= cd_rmask;
        mem_wmask <= cd_wmask;
        mem_wdata <= cd_wdata;
      end
    end
  end

  // Protocol checks on the requesters; violations are reported but the request is still dropped.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!((|dmem_rmask) && (|dmem_wmask)))
        else $warning("mem_arbiter: dmem read and write masks both set");
      assert (!((|(dmem_rmask | dmem_wmask)) && (d_pend || d_busy)))
        else $warning("mem_arbiter: dmem request dropped, one already outstanding");
      assert (!((|imem_rmask) && (i_pend || i_busy)))
        else $warning("mem_arbiter: imem request dropped, one already outstanding");
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random legal traffic,
// compared each cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int LIMIT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  imem_rmask, dmem_rmask, dmem_wmask;
  logic        imem_resp, dmem_resp;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_rmask, mem_wmask;
  logic        mem_resp;

  int vectors = 0;
  int miscompares = 0;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  // Reference model: one waiting request per requester, one transaction in flight on the port.
  typedef struct {
    bit          v;
    logic [31:0] addr;
    logic [3:0]  rm;
    logic [3:0]  wm;
    logic [31:0] wd;
  } req_t;

  req_t        slot [2];   // index 0 = imem, 1 = dmem
  bit          busy;
  int          own;
  int          starve;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_rmask, e_wmask;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) slot[k] = '{v: 1'b0, addr: '0, rm: '0, wm: '0, wd: '0};
    busy = 1'b0; own = 0; starve = 0;
    e_addr = '0; e_wdata = '0; e_rmask = '0; e_wmask = '0;
  endtask

  task automatic model_step();
    req_t cand [2];
    bit   done, free;
    int   win;
    if (rst) begin
      model_reset();
      return;
    end
    done = busy && mem_resp;
    free = !busy || done;
    cand[0] = slot[0];
    cand[1] = slot[1];
    if (!slot[0].v && (|imem_rmask) && !(busy && own == 0 && !done))
      cand[0] = '{v: 1'b1, addr: imem_addr, rm: imem_rmask, wm: 4'h0, wd: 32'h0};
    if (!slot[1].v && (|(dmem_rmask | dmem_wmask)) && !(busy && own == 1 && !done))
      cand[1] = '{v: 1'b1, addr: dmem_addr, rm: dmem_rmask, wm: dmem_wmask, wd: dmem_wdata};
    win = -1;
    if (free) begin
      if (cand[0].v && (!cand[1].v || starve == LIMIT)) win = 0;
      else if (cand[1].v) win = 1;
    end
    if (!cand[0].v || win == 0) starve = 0;
    else if (win == 1 && starve < LIMIT) starve++;
    for (int k = 0; k < 2; k++) begin
      slot[k] = cand[k];
      if (win == k) slot[k].v = 1'b0;
    end
    e_rmask = '0;
    e_wmask = '0;
    if (win >= 0) begin
      e_addr = cand[win].addr; e_rmask = cand[win].rm;
      e_wmask = cand[win].wm;  e_wdata = cand[win].wd;
      busy = 1'b1; own = win;
    end else if (free) begin
      busy = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic check_outputs();
    bit done_i, done_d;
    done_i = busy && mem_resp && own == 0;
    done_d = busy && mem_resp && own == 1;
    chk("imem_resp",  32'(imem_resp),  32'(done_i));
    chk("imem_rdata", imem_rdata,      done_i ? mem_rdata : 32'h0);
    chk("dmem_resp",  32'(dmem_resp),  32'(done_d));
    chk("dmem_rdata", dmem_rdata,      done_d ? mem_rdata : 32'h0);
    chk("mem_addr",   mem_addr,        e_addr);
    chk("mem_rmask",  32'(mem_rmask),  32'(e_rmask));
    chk("mem_wmask",  32'(mem_wmask),  32'(e_wmask));
    chk("mem_wdata",  mem_wdata,       e_wdata);
  endtask

  // One clock: compare at the falling edge, advance the model, then drop all one-cycle pulses.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
    imem_rmask = '0; dmem_rmask = '0; dmem_wmask = '0; mem_resp = 1'b0;
  endtask

  task automatic expect_issue(input string tag, input logic [31:0] addr);
    chk({tag, "_addr"}, mem_addr, addr);
    chk({tag, "_pulse"}, 32'(|(mem_rmask | mem_wmask)), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    imem_addr = '0; imem_rmask = '0; dmem_addr = '0; dmem_rmask = '0; dmem_wmask = '0;
    dmem_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
    tick();

    // 1: single dmem read, one-cycle latency to the port, response routed to dmem
    dmem_addr = 32'h1000; dmem_rmask = 4'h1;
    tick();
    chk("t1_addr", mem_addr, 32'h1000);
    chk("t1_rmask", 32'(mem_rmask), 32'h1);
    tick();
    chk("t1_rmask_pulse", 32'(mem_rmask), 32'h0);
    mem_resp = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("t1_dresp", 32'(dmem_resp), 32'd1);
    chk("t1_drdata", dmem_rdata, 32'hDEADBEEF);
    chk("t1_iresp", 32'(imem_resp), 32'd0);
    tick();

    // 2: simultaneous requests, dmem write first, imem keeps its stored address
    imem_addr = 32'h6000_0000; imem_rmask = 4'hF;
    dmem_addr = 32'h2000; dmem_wmask = 4'hF; dmem_wdata = 32'h1234_5678;
    tick();
    imem_addr = 32'h0BAD_0000;
    chk("t2_wmask", 32'(mem_wmask), 32'hF);
    chk("t2_addr", mem_addr, 32'h2000);
    chk("t2_wdata", mem_wdata, 32'h1234_5678);
    tick();
    mem_resp = 1'b1;
    tick();
    chk("t2_irmask", 32'(mem_rmask), 32'hF);
    chk("t2_iaddr", mem_addr, 32'h6000_0000);
    mem_resp = 1'b1; mem_rdata = 32'hC0DE_0001;
    #1;
    chk("t2_iresp", 32'(imem_resp), 32'd1);
    chk("t2_irdata", imem_rdata, 32'hC0DE_0001);
    chk("t2_dresp", 32'(dmem_resp), 32'd0);
    tick();

    // 3: starvation bound of two dmem grants, then imem, then the count restarts
    imem_addr = 32'h7000; imem_rmask = 4'hF;
    dmem_addr = 32'hA0; dmem_rmask = 4'hF;
    tick();
    expect_issue("t3_d0", 32'hA0);
    for (int k = 1; k <= 3; k++) begin
      mem_resp = 1'b1;
      if (k < 3) begin
        dmem_addr = 32'hA0 + 32'(4 * k); dmem_rmask = 4'hF;
      end
      tick();
      if (k == 1) expect_issue("t3_d1", 32'hA4);
      if (k == 2) expect_issue("t3_i", 32'h7000);
      if (k == 3) expect_issue("t3_d2", 32'hA8);
    end
    imem_addr = 32'h7100; imem_rmask = 4'hF;
    tick();
    for (int k = 0; k < 3; k++) begin
      mem_resp = 1'b1;
      if (k < 2) begin
        dmem_addr = 32'hB0 + 32'(4 * k); dmem_rmask = 4'hF;
      end
      tick();
      if (k < 2) expect_issue("t3_restart_d", 32'hB0 + 32'(4 * k));
      else       expect_issue("t3_restart_i", 32'h7100);
    end
    mem_resp = 1'b1;
    tick();
    tick();

    // 4: response while idle is ignored
    mem_resp = 1'b1; mem_rdata = 32'hAAAA_5555;
    #1;
    chk("t4_iresp", 32'(imem_resp), 32'd0);
    chk("t4_dresp", 32'(dmem_resp), 32'd0);
    chk("t4_drdata", dmem_rdata, 32'h0);
    tick();
    chk("t4_masks", 32'({mem_rmask, mem_wmask}), 32'h0);

    // 5: reset during a dmem read; the late response is ignored
    dmem_addr = 32'h3000; dmem_rmask = 4'h3;
    tick();
    tick();
    rst = 1'b1;
    model_reset();
    #1;
    chk("t5_addr", mem_addr, 32'h0);
    chk("t5_rmask", 32'(mem_rmask), 32'h0);
    tick();
    rst = 1'b0;
    mem_resp = 1'b1; mem_rdata = 32'h5555_AAAA;
    #1;
    chk("t5_late_dresp", 32'(dmem_resp), 32'd0);
    chk("t5_late_drdata", dmem_rdata, 32'h0);
    tick();
    chk("t5_idle_masks", 32'({mem_rmask, mem_wmask}), 32'h0);

    // 6: second dmem request while dmem owns the port is dropped
    dmem_addr = 32'h4000; dmem_rmask = 4'hF;
    tick();
    dmem_addr = 32'h4444; dmem_rmask = 4'hF;
    tick();
    chk("t6_no_reissue", 32'(mem_rmask), 32'h0);
    mem_resp = 1'b1;
    tick();
    tick();
    chk("t6_addr_held", mem_addr, 32'h4000);
    chk("t6_masks", 32'({mem_rmask, mem_wmask}), 32'h0);

    // Random legal traffic against the model
    for (int n = 0; n < 600; n++) begin
      bit done;
      mem_resp  = busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;
      done      = busy && mem_resp;
      imem_addr = $urandom & 32'hFFFF_FFFC;
      dmem_addr = $urandom & 32'hFFFF_FFFC;
      dmem_wdata = $urandom;
      if (!slot[0].v && !(busy && own == 0 && !done) && $urandom_range(0, 1) == 1)
        imem_rmask = 4'($urandom_range(1, 15));
      if (!slot[1].v && !(busy && own == 1 && !done) && $urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 1) == 1) dmem_wmask = 4'($urandom_range(1, 15));
        else                           dmem_rmask = 4'($urandom_range(1, 15));
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
